// File: rtl/add_tree_accum.sv
`timescale 1ns/1ps
// Pipelined NUM_INPUTS-wide unsigned adder tree with an optional saturating block accumulator.
// Latency: LEVELS+1 cycles from an accepted beat (mode 0) or from the accepted last beat (mode 1).
// Backpressure: the whole pipeline freezes while a result is held unconsumed; in_ready = !(out_valid && !out_ready).
module add_tree_accum #(
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int NUM_INPUTS        = 8,
    parameter int ACC_MODE          = 1,
    parameter int OUT_W             = 21
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    in_last,
    input  logic [ELEMENT_BIT_DEPTH*NUM_INPUTS-1:0] addend_array,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [OUT_W-1:0]                        out_sum,
    output logic                                    out_overflow
);

    localparam int EBD    = ELEMENT_BIT_DEPTH;
    localparam int LEVELS = $clog2(NUM_INPUTS);
    localparam int TREE_W = EBD + LEVELS;
    localparam int WW     = ((TREE_W > OUT_W) ? TREE_W : OUT_W) + 1;

    logic en;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Level k holds NUM_INPUTS>>k partial sums, each one bit wider than its operands.
    genvar k;
    generate
        for (k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int W   = EBD + k;
            localparam int PW  = W - 1;
            localparam int CNT = NUM_INPUTS >> k;

            logic [W*CNT-1:0]    sum_q;
            logic                vld_q;
            logic                last_q;
            logic [PW*2*CNT-1:0] prev;
            logic                prev_vld;
            logic                prev_last;

            if (k == 1) begin : g_src
                assign prev      = addend_array;
                assign prev_vld  = in_valid && en;
                assign prev_last = in_last;
            end else begin : g_src
                assign prev      = g_lvl[k-1].sum_q;
                assign prev_vld  = g_lvl[k-1].vld_q;
                assign prev_last = g_lvl[k-1].last_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    vld_q  <= 1'b0;
                    last_q <= 1'b0;
                end else if (en) begin
                    vld_q  <= prev_vld;
                    last_q <= prev_last;
                    for (int j = 0; j < CNT; j++) begin
                        sum_q[j*W +: W] <= {1'b0, prev[2*j*PW +: PW]} + {1'b0, prev[(2*j+1)*PW +: PW]};
                    end
                end
            end
        end
    endgenerate

    logic [TREE_W-1:0] tree_sum;
    logic              tree_vld;
    logic              tree_last;

    assign tree_sum  = g_lvl[LEVELS].sum_q;
    assign tree_vld  = g_lvl[LEVELS].vld_q;
    assign tree_last = g_lvl[LEVELS].last_q;

    logic [OUT_W-1:0] acc;
    logic             acc_ovf;
    logic [WW-1:0]    base;
    logic [WW-1:0]    acc_next;
    logic [WW-1:0]    max_val;
    logic [OUT_W-1:0] clamped;
    logic             ovf_new;
    logic             done;

    always_comb begin
        base     = (ACC_MODE != 0) ? WW'(acc) : '0;
        acc_next = base + WW'(tree_sum);
        max_val  = WW'({OUT_W{1'b1}});
        ovf_new  = acc_next > max_val;
        clamped  = ovf_new ? {OUT_W{1'b1}} : acc_next[OUT_W-1:0];
        done     = tree_vld && ((ACC_MODE == 0) || tree_last);
    end

    // With en high the held result is either absent or being consumed, so out_valid simply follows done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
            acc          <= '0;
            acc_ovf      <= 1'b0;
        end else if (en) begin
            out_valid <= done;
            if (done) begin
                out_sum      <= clamped;
                out_overflow <= ovf_new | ((ACC_MODE != 0) && acc_ovf);
                acc          <= '0;
                acc_ovf      <= 1'b0;
            end else if (tree_vld) begin
                acc     <= clamped;
                acc_ovf <= acc_ovf | ovf_new;
            end
        end
    end

endmodule

// File: tb/tb_add_tree_accum.sv
`timescale 1ns/1ps
// Bench for add_tree_accum: three instances (mode 0, mode 1, mode 1 with narrow output) against a block-sum scoreboard.
module tb_add_tree_accum;

    localparam int EBD = 14;
    localparam int N   = 8;
    localparam int DW  = EBD * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid[3];
    logic          in_last[3];
    logic          out_ready[3];
    logic          in_ready[3];
    logic          out_valid[3];
    logic          out_ovf[3];
    logic [DW-1:0] addend[3];
    logic [20:0]   sum0;
    logic [20:0]   sum1;
    logic [16:0]   sum2;

    add_tree_accum #(.ELEMENT_BIT_DEPTH(EBD), .NUM_INPUTS(N), .ACC_MODE(0), .OUT_W(21)) u_m0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_last(in_last[0]),
        .addend_array(addend[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_overflow(out_ovf[0]));

    add_tree_accum #(.ELEMENT_BIT_DEPTH(EBD), .NUM_INPUTS(N), .ACC_MODE(1), .OUT_W(21)) u_m1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_last(in_last[1]),
        .addend_array(addend[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_overflow(out_ovf[1]));

    add_tree_accum #(.ELEMENT_BIT_DEPTH(EBD), .NUM_INPUTS(N), .ACC_MODE(1), .OUT_W(17)) u_ov (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_last(in_last[2]),
        .addend_array(addend[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_overflow(out_ovf[2]));

    typedef struct {
        longint s;
        bit     o;
    } res_t;

    int     mode_p[3] = '{0, 1, 1};
    int     outw_p[3] = '{21, 21, 17};
    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    longint m_acc[3];
    bit     m_ovf[3];
    res_t   q[3][$];
    int     hs_cnt[3];
    longint hs_t[3][$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sum_of(input int d);
        case (d)
            0:       return longint'(sum0);
            1:       return longint'(sum1);
            default: return longint'(sum2);
        endcase
    endfunction

    function automatic longint tree_sum(input logic [DW-1:0] v);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(v[i*EBD +: EBD]);
        return s;
    endfunction

    function automatic logic [DW-1:0] fill(input int val);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*EBD +: EBD] = EBD'(val);
        return r;
    endfunction

    function automatic logic [DW-1:0] ramp(input int b);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*EBD +: EBD] = EBD'(b + i);
        return r;
    endfunction

    // Reference behaviour: plain integer block sums with saturation at 2^OUT_W-1.
    task automatic model_beat(input int d, input longint ts, input bit last);
        longint maxv = (longint'(1) << outw_p[d]) - 1;
        res_t   r;
        if (mode_p[d] == 0) begin
            r.s = (ts > maxv) ? maxv : ts;
            r.o = ts > maxv;
            q[d].push_back(r);
        end else begin
            m_acc[d] += ts;
            if (m_acc[d] > maxv) begin
                m_acc[d] = maxv;
                m_ovf[d] = 1'b1;
            end
            if (last) begin
                r.s = m_acc[d];
                r.o = m_ovf[d];
                q[d].push_back(r);
                m_acc[d] = 0;
                m_ovf[d] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_acc[d] = 0;
            m_ovf[d] = 1'b0;
            hs_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    q[d].delete();
                    m_acc[d] = 0;
                    m_ovf[d] = 1'b0;
                end else begin
                    if (out_valid[d]) begin
                        if (q[d].size() == 0) begin
                            chk($sformatf("unexpected_out_d%0d", d), 1, 0);
                        end else begin
                            chk($sformatf("sb_sum_d%0d", d), sum_of(d), q[d][0].s);
                            chk($sformatf("sb_ovf_d%0d", d), longint'(out_ovf[d]), longint'(q[d][0].o));
                        end
                        if (out_ready[d]) begin
                            if (q[d].size() != 0) q[d].delete(0);
                            hs_cnt[d]++;
                            hs_t[d].push_back(cyc);
                        end
                    end
                    if (in_valid[d] && in_ready[d]) model_beat(d, tree_sum(addend[d]), in_last[d]);
                end
            end
        end
    end

    // Leaves in_valid high so consecutive calls stream beats back to back; returns #1 after the accepting edge.
    task automatic send(input int d, input logic [DW-1:0] v, input logic last);
        int n   = 0;
        bit acc = 1'b0;
        addend[d]   = v;
        in_last[d]  = last;
        in_valid[d] = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready[d];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk($sformatf("accept_timeout_d%0d", d), 0, 1);
    endtask

    task automatic idle(input int d);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    // Latency counted in cycles starting with the acceptance cycle itself.
    task automatic wait_out(input int d, output int lat);
        int n = 1;
        while (!out_valid[d] && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = n;
        if (!out_valid[d]) chk($sformatf("out_timeout_d%0d", d), 0, 1);
    endtask

    initial begin
        int     lat;
        int     h0;
        int     sz;
        longint c0;
        longint got[$];

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_last[d]   = 1'b0;
            out_ready[d] = 1'b1;
            addend[d]    = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_out_valid_d%0d", d), longint'(out_valid[d]), 0);
            chk($sformatf("rst_out_sum_d%0d", d), sum_of(d), 0);
            chk($sformatf("rst_out_ovf_d%0d", d), longint'(out_ovf[d]), 0);
            chk($sformatf("rst_in_ready_d%0d", d), longint'(in_ready[d]), 1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("model_pin_ramp", tree_sum(ramp(1)), 36);
        chk("model_pin_full", 4 * tree_sum(fill(16383)), 524256);

        // Mode 0 single beat, elements 1..8.
        send(0, ramp(1), 1'b0);
        idle(0);
        wait_out(0, lat);
        chk("m0_latency", lat, 4);
        chk("m0_sum", sum_of(0), 36);
        chk("m0_ovf", longint'(out_ovf[0]), 0);
        @(posedge clk);
        #1;
        chk("m0_pulse_clears", longint'(out_valid[0]), 0);

        // Mode 1, four full-scale beats in one block.
        h0 = hs_cnt[1];
        send(1, fill(16383), 1'b0);
        send(1, fill(16383), 1'b0);
        send(1, fill(16383), 1'b0);
        chk("m1_no_early_out", hs_cnt[1] - h0, 0);
        send(1, fill(16383), 1'b1);
        idle(1);
        wait_out(1, lat);
        chk("m1_latency", lat, 4);
        chk("m1_sum", sum_of(1), 524256);
        chk("m1_ovf", longint'(out_ovf[1]), 0);
        @(posedge clk);
        #1;
        chk("m1_single_pulse", hs_cnt[1] - h0, 1);
        chk("m1_valid_clears", longint'(out_valid[1]), 0);

        // Back-pressure: three results held behind a stalled consumer.
        out_ready[0] = 1'b0;
        send(0, fill(1), 1'b0);
        send(0, fill(2), 1'b0);
        send(0, fill(3), 1'b0);
        idle(0);
        wait_out(0, lat);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready_low", longint'(in_ready[0]), 0);
            chk("bp_sum_held", sum_of(0), 8);
        end
        out_ready[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[0]) got.push_back(sum_of(0));
            @(posedge clk);
            #1;
        end
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_first", got[0], 8);
            chk("bp_second", got[1], 16);
            chk("bp_third", got[2], 24);
        end

        // Saturation with OUT_W=17, then a clean single-beat block.
        send(2, fill(16383), 1'b0);
        send(2, fill(16383), 1'b1);
        idle(2);
        wait_out(2, lat);
        chk("ov_sum_sat", sum_of(2), 131071);
        chk("ov_flag", longint'(out_ovf[2]), 1);
        send(2, fill(1), 1'b1);
        idle(2);
        wait_out(2, lat);
        chk("ov_next_sum", sum_of(2), 8);
        chk("ov_next_flag", longint'(out_ovf[2]), 0);

        // Reset in the middle of a block while another instance holds a result.
        out_ready[0] = 1'b0;
        send(0, fill(5), 1'b0);
        idle(0);
        send(1, fill(7), 1'b0);
        send(1, fill(7), 1'b0);
        idle(1);
        wait_out(0, lat);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", longint'(out_valid[0]), 0);
        chk("arst_out_sum", sum_of(0), 0);
        chk("arst_in_ready", longint'(in_ready[0]), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        send(1, fill(2), 1'b1);
        idle(1);
        wait_out(1, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_sum", sum_of(1), 16);
        chk("post_rst_ovf", longint'(out_ovf[1]), 0);

        // Mode 0 streaming at full rate; in_last toggles but must be ignored.
        h0 = hs_cnt[0];
        c0 = cyc;
        for (int b = 0; b < 20; b++) send(0, ramp((b * 797) % 16000), (b % 3) == 0);
        idle(0);
        chk("b2b_accept_cycles", cyc - c0, 20);
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_count", hs_cnt[0] - h0, 20);
        sz = hs_t[0].size();
        if (sz >= 20) chk("b2b_one_per_cycle", hs_t[0][sz-1] - hs_t[0][sz-20], 19);

        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("drained_d%0d", d), q[d].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
